// File: rtl/lotr_pkg.sv
// lotr_pkg: shared LOTR tile constants, memory map and loader frame definitions.
package lotr_pkg;
    localparam logic [31:0] I_MEM_OFFSET = 32'h0000_0000;
    localparam logic [31:0] SIZE_I_MEM = 32'h0000_1000;
    localparam logic [31:0] D_MEM_OFFSET = 32'h0001_0000;
    localparam logic [31:0] SIZE_D_MEM = 32'h0000_1000;
    localparam logic [7:0] LOAD_OP_WRITE = 8'hA5;
    localparam logic [7:0] LOAD_OP_DONE = 8'h5A;
    // opcode + 4 address bytes + 2 count bytes
    localparam int LOAD_HDR_BYTES = 7;
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR,
        LD_CNT,
        LD_DATA,
        LD_WRITE,
        LD_DROP,
        LD_DONE
    } load_state_e;
endpackage

// File: rtl/lotr_mem_loader_if.sv
// lotr_mem_loader_if: load byte stream plus memory write port and core control of the loader.
interface lotr_mem_loader_if;
    logic ByteValidQnnnH;
    logic [7:0] ByteDataQnnnH;
    logic ByteReadyQnnnH;
    logic MemWrEnQnnnH;
    logic MemWrSelQnnnH;
    logic [31:0] MemWrAddrQnnnH;
    logic [31:0] MemWrDataQnnnH;
    logic CoreRstQnnnH;
    logic LoadErrQnnnH;
    modport master(input ByteValidQnnnH, ByteDataQnnnH,
                   output ByteReadyQnnnH, MemWrEnQnnnH, MemWrSelQnnnH, MemWrAddrQnnnH,
                          MemWrDataQnnnH, CoreRstQnnnH, LoadErrQnnnH);
    modport slave(output ByteValidQnnnH, ByteDataQnnnH,
                  input ByteReadyQnnnH, MemWrEnQnnnH, MemWrSelQnnnH, MemWrAddrQnnnH,
                        MemWrDataQnnnH, CoreRstQnnnH, LoadErrQnnnH);
endinterface

// File: rtl/lotr_mem_loader_asm.sv
// lotr_mem_loader_asm: little-endian byte-to-word shift assembler with word_done on the 4th byte.
module lotr_mem_loader_asm (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift,
    input  logic [7:0] din,
    output logic [31:0] word_next,
    output logic first,
    output logic word_done
);
    logic [31:0] word;
    logic [1:0] cnt;
    assign word_next = {din, word[31:8]};
    assign first = cnt == 2'd0;
    assign word_done = shift && !clr && cnt == 2'd3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift) begin
            word <= word_next;
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/lotr_mem_loader.sv
// lotr_mem_loader: front-door program loader; parses the byte stream, range-checks bursts
// and writes assembled words into I/D memory while holding the cores in reset until DONE.
module lotr_mem_loader #(
    parameter logic [31:0] I_MEM_OFFSET = lotr_pkg::I_MEM_OFFSET,
    parameter logic [31:0] SIZE_I_MEM = lotr_pkg::SIZE_I_MEM,
    parameter logic [31:0] D_MEM_OFFSET = lotr_pkg::D_MEM_OFFSET,
    parameter logic [31:0] SIZE_D_MEM = lotr_pkg::SIZE_D_MEM
) (
    input logic QClk,
    input logic RstQnnnH,
    lotr_mem_loader_if.master bus
);
    import lotr_pkg::*;
    load_state_e st, st_n;
    logic [2:0] hc;
    logic [31:0] a, off, lim, word_next, wr_addr, wr_data;
    logic [32:0] ax;
    logic [15:0] n, wc, n_full;
    logic [7:0] b;
    logic sel, ready, wr_en, wr_sel, core_rst, err;
    logic hs, in_i, in_d, hdr_ok, wc_last, first, word_done, active, overrun, last_cnt;
    assign b = bus.ByteDataQnnnH;
    assign hs = bus.ByteValidQnnnH && ready;
    assign active = st == LD_DATA || st == LD_DROP;
    assign ax = {1'b0, a};
    assign in_i = ax >= {1'b0, I_MEM_OFFSET} && ax < {1'b0, I_MEM_OFFSET} + {1'b0, SIZE_I_MEM};
    assign in_d = ax >= {1'b0, D_MEM_OFFSET} && ax < {1'b0, D_MEM_OFFSET} + {1'b0, SIZE_D_MEM};
    assign hdr_ok = a[1:0] == 2'd0 && (in_i || in_d);
    assign n_full = {b, n[15:8]};
    assign last_cnt = hs && st == LD_CNT && hc == 3'(LOAD_HDR_BYTES - 2);
    assign wc_last = wc + 16'd1 == n;
    // a word starting at or past the region end is never written
    assign overrun = st == LD_DATA && hs && first && off >= lim;
    lotr_mem_loader_asm u_asm (
        .clk(QClk),
        .rst(RstQnnnH),
        .clr(!active),
        .shift(hs && active),
        .din(b),
        .word_next(word_next),
        .first(first),
        .word_done(word_done)
    );
    always_comb begin
        st_n = st;
        case (st)
            LD_IDLE:  if (hs) st_n = b == LOAD_OP_WRITE ? LD_ADDR : b == LOAD_OP_DONE ? LD_DONE : LD_IDLE;
            LD_ADDR:  if (hs && hc == 3'(LOAD_HDR_BYTES - 4)) st_n = LD_CNT;
            LD_CNT:   if (last_cnt) st_n = n_full == 16'd0 ? LD_IDLE : hdr_ok ? LD_DATA : LD_DROP;
            LD_DATA:  st_n = overrun ? LD_DROP : word_done ? LD_WRITE : LD_DATA;
            LD_WRITE: st_n = wc_last ? LD_IDLE : LD_DATA;
            LD_DROP:  if (word_done && wc_last) st_n = LD_IDLE;
            default:  st_n = st;
        endcase
    end
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            st <= LD_IDLE;
            hc <= '0;
            a <= '0;
            n <= '0;
            wc <= '0;
            off <= '0;
            lim <= '0;
            sel <= 1'b0;
            ready <= 1'b0;
            wr_en <= 1'b0;
            wr_sel <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            core_rst <= 1'b1;
            err <= 1'b0;
        end else begin
            st <= st_n;
            ready <= st_n != LD_WRITE && st_n != LD_DONE;
            core_rst <= st_n != LD_DONE;
            wr_en <= st_n == LD_WRITE;
            if (st == LD_IDLE) hc <= '0;
            else if (hs && (st == LD_ADDR || st == LD_CNT)) hc <= hc + 3'd1;
            if (hs && st == LD_ADDR) a <= {b, a[31:8]};
            if (hs && st == LD_CNT) n <= n_full;
            if (last_cnt) begin
                wc <= '0;
                sel <= !in_i;
                off <= a - (in_i ? I_MEM_OFFSET : D_MEM_OFFSET);
                lim <= in_i ? SIZE_I_MEM : SIZE_D_MEM;
            end
            if (st == LD_DATA && word_done) begin
                wr_sel <= sel;
                wr_addr <= off;
                wr_data <= word_next;
            end
            if (st == LD_WRITE) begin
                wc <= wc + 16'd1;
                off <= off + 32'd4;
            end
            if (st == LD_DROP && word_done) wc <= wc + 16'd1;
            if ((hs && st == LD_IDLE && b != LOAD_OP_WRITE && b != LOAD_OP_DONE) ||
                (last_cnt && n_full != 16'd0 && !hdr_ok) || overrun) err <= 1'b1;
        end
    end
    assign bus.ByteReadyQnnnH = ready;
    assign bus.MemWrEnQnnnH = wr_en;
    assign bus.MemWrSelQnnnH = wr_sel;
    assign bus.MemWrAddrQnnnH = wr_addr;
    assign bus.MemWrDataQnnnH = wr_data;
    assign bus.CoreRstQnnnH = core_rst;
    assign bus.LoadErrQnnnH = err;
endmodule

// File: tb/tb_lotr_mem_loader.sv
// tb_lotr_mem_loader: directed scenario tests for the program loader with hand-computed writes.
module tb_lotr_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    int nwr = 0;
    logic prev_en = 1'b0;
    logic b2b = 1'b0;
    lotr_mem_loader_if bus ();
    lotr_mem_loader dut (.QClk(clk), .RstQnnnH(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.MemWrEnQnnnH) begin
            nwr++;
            if (prev_en) b2b = 1'b1;
        end
        prev_en = bus.MemWrEnQnnnH;
    end
    task automatic send(input logic [7:0] v);
        int t = 0;
        @(negedge clk);
        bus.ByteValidQnnnH = 1'b1;
        bus.ByteDataQnnnH = v;
        while (!bus.ByteReadyQnnnH && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++;
            $display("FAIL send_timeout byte=%02h ready stayed 0, required 1", v);
            bus.ByteValidQnnnH = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.ByteValidQnnnH = 1'b0;
        end
    endtask
    task automatic send_hdr(input logic [31:0] addr, input logic [15:0] cnt);
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(addr[8*i+:8]);
        send(cnt[7:0]);
        send(cnt[15:8]);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ByteValidQnnnH = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.ByteReadyQnnnH, bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.CoreRstQnnnH, bus.LoadErrQnnnH} !== 5'b00010)
            $display("FAIL reset_ctrl got %b required 00010", {bus.ByteReadyQnnnH, bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.CoreRstQnnnH, bus.LoadErrQnnnH});
        else passed++;
        total++;
        if ({bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH} !== 64'd0)
            $display("FAIL reset_addr_data got %h required 0", {bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.ByteReadyQnnnH !== 1'b1) $display("FAIL reset_ready_after got %b required 1", bus.ByteReadyQnnnH);
        else passed++;
    endtask
    task automatic test_imem_write();
        int w0 = nwr;
        send_hdr(32'h0, 16'd2);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        total++;
        if ({bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH} !== {2'b10, 32'h0, 32'h00000013})
            $display("FAIL imem_word0 got en=%b sel=%b addr=%h data=%h required en=1 sel=0 addr=0 data=00000013",
                     bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH);
        else passed++;
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        total++;
        if ({bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH} !== {2'b10, 32'h4, 32'h00100093})
            $display("FAIL imem_word1 got en=%b sel=%b addr=%h data=%h required en=1 sel=0 addr=4 data=00100093",
                     bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (nwr - w0 !== 2 || b2b !== 1'b0 || bus.LoadErrQnnnH !== 1'b0)
            $display("FAIL imem_count got writes=%0d b2b=%b err=%b required 2 0 0", nwr - w0, b2b, bus.LoadErrQnnnH);
        else passed++;
    endtask
    task automatic test_zero_and_bad_op();
        int w0 = nwr;
        send_hdr(32'h0, 16'd0);
        repeat (2) @(negedge clk);
        total++;
        if (nwr - w0 !== 0 || bus.LoadErrQnnnH !== 1'b0 || bus.ByteReadyQnnnH !== 1'b1)
            $display("FAIL zero_count got writes=%0d err=%b ready=%b required 0 0 1", nwr - w0, bus.LoadErrQnnnH, bus.ByteReadyQnnnH);
        else passed++;
        send(8'h33);
        total++;
        if (bus.LoadErrQnnnH !== 1'b1 || bus.ByteReadyQnnnH !== 1'b1)
            $display("FAIL bad_opcode got err=%b ready=%b required 1 1", bus.LoadErrQnnnH, bus.ByteReadyQnnnH);
        else passed++;
    endtask
    task automatic test_reset_mid_frame();
        int w0;
        do_reset();
        w0 = nwr;
        send_hdr(32'h0, 16'd1);
        send(8'hAA); send(8'hBB);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.ByteReadyQnnnH, bus.MemWrEnQnnnH, bus.CoreRstQnnnH, bus.LoadErrQnnnH} !== 4'b0010 || bus.MemWrAddrQnnnH !== 32'd0)
            $display("FAIL midframe_reset got ready=%b en=%b crst=%b err=%b addr=%h required 0 0 1 0 0",
                     bus.ByteReadyQnnnH, bus.MemWrEnQnnnH, bus.CoreRstQnnnH, bus.LoadErrQnnnH, bus.MemWrAddrQnnnH);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        send_hdr(32'h10, 16'd1);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        total++;
        if ({bus.MemWrEnQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH} !== {1'b1, 32'h10, 32'h11223344})
            $display("FAIL after_reset_write got en=%b addr=%h data=%h required 1 00000010 11223344",
                     bus.MemWrEnQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (nwr - w0 !== 1) $display("FAIL midframe_writes got %0d required 1", nwr - w0);
        else passed++;
    endtask
    task automatic test_overrun();
        int w0;
        do_reset();
        w0 = nwr;
        send_hdr(32'h0000_0FFC, 16'd2);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        total++;
        if ({bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH, bus.LoadErrQnnnH} !== {2'b10, 32'hFFC, 32'h44332211, 1'b0})
            $display("FAIL overrun_last_word got en=%b sel=%b addr=%h data=%h err=%b required 1 0 00000ffc 44332211 0",
                     bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH, bus.LoadErrQnnnH);
        else passed++;
        send(8'h55);
        total++;
        if (bus.LoadErrQnnnH !== 1'b1) $display("FAIL overrun_err got %b required 1", bus.LoadErrQnnnH);
        else passed++;
        send(8'h66); send(8'h77); send(8'h88);
        repeat (2) @(negedge clk);
        total++;
        if (nwr - w0 !== 1 || bus.ByteReadyQnnnH !== 1'b1)
            $display("FAIL overrun_drop got writes=%0d ready=%b required 1 1", nwr - w0, bus.ByteReadyQnnnH);
        else passed++;
    endtask
    task automatic test_unaligned_then_done();
        int w0;
        logic rdy_seen = 1'b0;
        do_reset();
        w0 = nwr;
        send_hdr(32'h0001_0002, 16'd1);
        total++;
        if (bus.LoadErrQnnnH !== 1'b1) $display("FAIL unaligned_err got %b required 1", bus.LoadErrQnnnH);
        else passed++;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        repeat (2) @(negedge clk);
        total++;
        if (nwr - w0 !== 0 || bus.ByteReadyQnnnH !== 1'b1)
            $display("FAIL unaligned_drop got writes=%0d ready=%b required 0 1", nwr - w0, bus.ByteReadyQnnnH);
        else passed++;
        send_hdr(32'h0001_0008, 16'd1);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        total++;
        if ({bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH} !== {2'b11, 32'h8, 32'hDEADBEEF})
            $display("FAIL dmem_write got en=%b sel=%b addr=%h data=%h required 1 1 00000008 deadbeef",
                     bus.MemWrEnQnnnH, bus.MemWrSelQnnnH, bus.MemWrAddrQnnnH, bus.MemWrDataQnnnH);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.CoreRstQnnnH !== 1'b1) $display("FAIL core_rst_before_done got %b required 1", bus.CoreRstQnnnH);
        else passed++;
        send(8'h5A);
        total++;
        if ({bus.CoreRstQnnnH, bus.ByteReadyQnnnH, bus.LoadErrQnnnH} !== 3'b001)
            $display("FAIL done got crst=%b ready=%b err=%b required 0 0 1", bus.CoreRstQnnnH, bus.ByteReadyQnnnH, bus.LoadErrQnnnH);
        else passed++;
        w0 = nwr;
        @(negedge clk);
        bus.ByteValidQnnnH = 1'b1;
        bus.ByteDataQnnnH = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ByteReadyQnnnH || !(bus.CoreRstQnnnH === 1'b0)) rdy_seen = 1'b1;
        end
        bus.ByteValidQnnnH = 1'b0;
        total++;
        if (rdy_seen !== 1'b0 || nwr - w0 !== 0)
            $display("FAIL done_hold got ready_or_crst_seen=%b writes=%0d required 0 0", rdy_seen, nwr - w0);
        else passed++;
    endtask
    initial begin
        bus.ByteValidQnnnH = 1'b0;
        bus.ByteDataQnnnH = 8'h00;
        test_reset();
        test_imem_write();
        test_zero_and_bad_op();
        test_reset_mid_frame();
        test_overrun();
        test_unaligned_then_done();
        total++;
        if (b2b !== 1'b0) $display("FAIL write_b2b got %b required 0", b2b);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lotr_mem_loader.md
# lotr_mem_loader

Front-door program loader for a LOTR tile: consumes a byte-serial load stream, assembles little-endian 32-bit words and writes them into the tile's instruction or data memory through a write port. It holds the cores in reset until the stream signals completion. It is the writer counterpart of the end-of-test memory snapshot path, and replaces backdoor memory loading on silicon/FPGA.

## Interface
- I_MEM_OFFSET, default lotr_pkg::I_MEM_OFFSET: base byte address of instruction memory
- SIZE_I_MEM, default lotr_pkg::SIZE_I_MEM: instruction memory size in bytes
- D_MEM_OFFSET, default lotr_pkg::D_MEM_OFFSET: base byte address of data memory
- SIZE_D_MEM, default lotr_pkg::SIZE_D_MEM: data memory size in bytes
- QClk  in  1  clock; one clock domain
- RstQnnnH  in  1  reset, asynchronous, active-high
- ByteValidQnnnH  in  1  load-stream byte valid
- ByteDataQnnnH  in  8  load-stream byte
- ByteReadyQnnnH  out  1  loader accepts byte; transfer = Valid & Ready on a QClk rising edge
- MemWrEnQnnnH  out  1  one-cycle word write strobe
- MemWrSelQnnnH  out  1  target: 0 = I-mem, 1 = D-mem
- MemWrAddrQnnnH  out  32  word-aligned byte offset within the selected memory
- MemWrDataQnnnH  out  32  write data
- CoreRstQnnnH  out  1  core reset hold; high until load done
- LoadErrQnnnH  out  1  sticky error flag

## Operation
- Frame: opcode byte, then for opcode 0xA5 (WRITE): 4 address bytes (LE), 2 count bytes N (LE, words), 4·N data bytes (each word LE). Opcode 0x5A (DONE) takes no payload. Any other opcode sets LoadErr and returns to IDLE.
- States: IDLE (await opcode) -> ADDR (4 bytes) -> CNT (2 bytes) -> DATA (4 bytes per word) -> WRITE (1 cycle) -> DATA or IDLE; DROP (consume remaining payload without writes); DONE (terminal).
- Header check on the last count byte: address must be aligned (addr[1:0]==0) and fall in [I_MEM_OFFSET, I_MEM_OFFSET+SIZE_I_MEM) or [D_MEM_OFFSET, D_MEM_OFFSET+SIZE_D_MEM). On failure set LoadErr and go to DROP for 4·N bytes. N=0 -> IDLE, no write, no error.
- MemWrSel is decided by region; MemWrAddr = address − region offset. The address advances by 4 per word.
- Region overrun mid-burst: a word whose address reaches the region end is not written. LoadErr is set and the remaining bytes of that word and of the burst go to DROP.
- Word and byte counters are 16 bits with no wrap. The burst ends when the written-word count equals N.
- DONE: CoreRst drops and ByteReady is held 0 until reset. Further bytes are never accepted.
- LoadErr does not block DONE. LoadErr clears only on reset.

## Timing
- Reset values: ByteReady 0, MemWrEn 0, MemWrSel 0, MemWrAddr 0, MemWrData 0, CoreRst 1, LoadErr 0; state IDLE.
- ByteReady = 1 in IDLE/ADDR/CNT/DATA/DROP, 0 in WRITE and DONE; registered, so ByteReady is 1 the first cycle after reset deasserts.
- Write latency: the handshake of a word's 4th byte in cycle t gives MemWrEn=1 in cycle t+1 with address/data/sel stable that cycle. MemWrEn is never high 2 consecutive cycles.
- Throughput: one word per 5 cycles at full ByteValid.
- CoreRst goes low the cycle after the 0x5A handshake.
- Valid low between bytes stalls any state with no timeout. Partial words are held.
- Reset mid-frame: immediate return to reset values. A partial word is discarded, no write is issued, and CoreRst goes back to 1.
- Error detection and LoadErr rise the cycle after the offending byte handshake.

## Structure
- lotr_pkg gains: typedef enum for loader states, LOAD_OP_WRITE = 8'hA5, LOAD_OP_DONE = 8'h5A, and a loader frame-length constant (header 7 bytes).
- One sub-module, lotr_mem_loader_asm: a byte-to-word shift assembler with byte counter and word_done pulse. The FSM, address/range check and counters live in the top module.
- State and counters use LOTR_MSFF-style flops with async reset on RstQnnnH.

## Test plan
- Stream A5, 00 00 00 00 (I-mem base 0), 02 00, bytes 13 00 00 00 93 00 10 00 -> writes sel=0 addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; MemWrEn pulses separated by ≥4 cycles.
- WRITE to D_MEM_OFFSET+8 with N=1, data EF BE AD DE, then 5A -> one write sel=1 addr 0x8 data 0xDEADBEEF; CoreRst low one cycle after the 5A handshake; ByteReady stays 0 after.
- Unaligned address D_MEM_OFFSET+2, N=1 -> no MemWrEn, LoadErr=1, 4 data bytes consumed, next opcode accepted normally.
- Burst starting at the last I-mem word with N=2 -> one write at offset SIZE_I_MEM−4, second word dropped, LoadErr=1.
- Opcode 0x33 -> LoadErr=1, IDLE; N=0 WRITE -> no write, no error.
- Reset asserted after 2 data bytes of a word -> no write, all outputs at reset values, CoreRst=1; a fresh frame after reset loads correctly.
